// File: rtl/i2s_tx_pkg.sv
// Shared constants and types for the I2S transmit path.
package i2s_tx_pkg;

    localparam int I2S_SLOT_W   = 32;
    localparam int I2S_SAMPLE_W = 24;
    localparam int I2S_BIT_W    = $clog2(2 * I2S_SLOT_W);

    // Bit-index window during which ws selects the right channel.
    localparam int I2S_WS_FIRST = I2S_SLOT_W - 1;
    localparam int I2S_WS_LAST  = 2 * I2S_SLOT_W - 2;

    typedef struct packed {
        logic [23:0] left;
        logic [23:0] right;
    } pcm_pair_t;

endpackage

// File: rtl/i2s_tx_clkgen.sv
// Bit-clock divider: toggles bck every bck_div+1 clk and flags the edges.
module i2s_tx_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] bck_div_i,
    output logic             bck_o,
    output logic             bck_rise_o,
    output logic             bck_fall_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             bck_q, bck_d;
    logic             run_s;
    logic             tc_s;

    assign run_s = en_i & ~reset_i;
    assign tc_s  = run_s & (cnt_q == div_q);

    // While idle the divider keeps reloading so the first half-period uses the current setting.
    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        bck_d = bck_q;
        if (!run_s) begin
            cnt_d = {DIV_W{1'b0}};
            div_d = bck_div_i;
            bck_d = 1'b0;
        end else if (tc_s) begin
            cnt_d = {DIV_W{1'b0}};
            div_d = bck_div_i;
            bck_d = ~bck_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Divider state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= {DIV_W{1'b0}};
            div_q <= bck_div_i;
            bck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
            bck_q <= bck_d;
        end
    end

    assign bck_o      = bck_q;
    assign bck_rise_o = tc_s & ~bck_q;
    assign bck_fall_o = tc_s & bck_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S serializer: buffers one stereo pair and shifts it out in 32-bit slots.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int SAMPLE_W = I2S_SAMPLE_W,
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int DIV_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [DIV_W-1:0]    bck_div,
    input  logic                mute,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                s_ready,
    output logic                i2s_bck,
    output logic                i2s_ws,
    output logic                i2s_d0,
    output logic                frame_strobe,
    output logic                underrun,
    input  logic                underrun_clr
);

    localparam int BIT_W   = $clog2(2 * SLOT_W);
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int PAD_W   = SLOT_W - SAMPLE_W;
    localparam logic [BIT_W-1:0] B_LAST   = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(2 * SLOT_W - 2);

    logic               run_s, accept_s, bck_fall_s, bck_rise_unused;
    logic [BIT_W-1:0]   b_q, b_d, idx_s;
    logic               ws_q, ws_d, d0_q, d0_d, strobe_q, strobe_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    pcm_pair_t          hold_q, hold_d;
    logic               full_q, full_d, armed_q, armed_d, under_q, under_d;

    assign run_s    = en & ~reset;
    assign s_ready  = run_s & ~full_q;
    assign accept_s = s_valid & s_ready;

    i2s_tx_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk_i      (clk),
        .reset_i    (reset),
        .en_i       (en),
        .bck_div_i  (bck_div),
        .bck_o      (i2s_bck),
        .bck_rise_o (bck_rise_unused),
        .bck_fall_o (bck_fall_s)
    );

    // Bit sequencing, frame load and sample handshake.
    always_comb begin
        b_d      = b_q;
        ws_d     = ws_q;
        d0_d     = d0_q;
        strobe_d = 1'b0;
        frame_d  = frame_q;
        hold_d   = hold_q;
        full_d   = full_q;
        armed_d  = armed_q;
        under_d  = under_q;
        idx_s    = {BIT_W{1'b0}};
        if (!run_s) begin
            b_d     = B_LAST;
            ws_d    = 1'b0;
            d0_d    = 1'b0;
            frame_d = {FRAME_W{1'b0}};
            hold_d  = '0;
            full_d  = 1'b0;
            armed_d = 1'b0;
        end else begin
            if (bck_fall_s) begin
                b_d  = b_q + BIT_W'(1);
                ws_d = (b_d >= WS_FIRST) && (b_d <= WS_LAST);
                // Negated index: b=0 picks the old frame's last bit, b=k picks bit k-1 MSB-first.
                idx_s = BIT_W'(0) - b_d;
                d0_d  = frame_q[idx_s];
                if (b_q == B_LAST) begin
                    strobe_d = 1'b1;
                    full_d   = 1'b0;
                    if (full_q && !mute) begin
                        frame_d = {hold_q.left, {PAD_W{1'b0}}, hold_q.right, {PAD_W{1'b0}}};
                    end else begin
                        frame_d = {FRAME_W{1'b0}};
                    end
                    if (!full_q && armed_q) begin
                        under_d = 1'b1;
                    end else begin
                        under_d = under_q;
                    end
                end else begin
                    strobe_d = 1'b0;
                end
            end else begin
                b_d = b_q;
            end
            if (accept_s) begin
                hold_d  = {s_left, s_right};
                full_d  = 1'b1;
                armed_d = 1'b1;
            end else begin
                armed_d = armed_q;
            end
        end
        if (underrun_clr) begin
            under_d = 1'b0;
        end else begin
            under_d = under_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_q      <= B_LAST;
            ws_q     <= 1'b0;
            d0_q     <= 1'b0;
            strobe_q <= 1'b0;
            frame_q  <= {FRAME_W{1'b0}};
            hold_q   <= '0;
            full_q   <= 1'b0;
            armed_q  <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            b_q      <= b_d;
            ws_q     <= ws_d;
            d0_q     <= d0_d;
            strobe_q <= strobe_d;
            frame_q  <= frame_d;
            hold_q   <= hold_d;
            full_q   <= full_d;
            armed_q  <= armed_d;
            under_q  <= under_d;
        end
    end

    assign i2s_ws       = ws_q;
    assign i2s_d0       = d0_q;
    assign frame_strobe = strobe_q;
    assign underrun     = under_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx against a time-arithmetic model of the I2S frame.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        reset, en, mute, s_valid, underrun_clr;
    logic [7:0]  bck_div;
    logic [23:0] s_left, s_right;
    logic        s_ready, i2s_bck, i2s_ws, i2s_d0, frame_strobe, underrun;

    always #5 clk = ~clk;

    i2s_tx dut (
        .clk(clk), .reset(reset), .en(en), .bck_div(bck_div), .mute(mute),
        .s_valid(s_valid), .s_left(s_left), .s_right(s_right), .s_ready(s_ready),
        .i2s_bck(i2s_bck), .i2s_ws(i2s_ws), .i2s_d0(i2s_d0),
        .frame_strobe(frame_strobe), .underrun(underrun), .underrun_clr(underrun_clr)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: t counts enabled clk edges; everything else follows from t and the divider.
    int          m_t, m_div;
    bit          m_full, m_armed, m_under, m_load, m_acc;
    logic [23:0] m_l, m_r;
    logic [63:0] m_cur, m_prev;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int per;
        m_load = 1'b0;
        m_acc  = 1'b0;
        if (reset || !en) begin
            m_t = 0; m_full = 1'b0; m_armed = 1'b0; m_cur = '0; m_prev = '0;
            if (reset) m_under = 1'b0;
        end else begin
            m_t++;
            per   = 2 * (m_div + 1);
            m_acc = s_valid && !m_full;
            if ((m_t % per) == 0 && (((m_t / per) - 1) % 64) == 0) begin
                m_load = 1'b1;
                m_prev = m_cur;
                m_cur  = (m_full && !mute) ? ((64'(m_l) << 40) | (64'(m_r) << 8)) : 64'd0;
                if (!m_full && m_armed) m_under = 1'b1;
            end
            if (m_acc) begin
                m_l = s_left; m_r = s_right; m_full = 1'b1; m_armed = 1'b1;
            end else if (m_load) begin
                m_full = 1'b0;
            end
        end
        if (underrun_clr && !reset) m_under = 1'b0;
    endtask

    task automatic tick();
        int half, f, b;
        logic e_ws, e_d0;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        half = m_div + 1;
        f    = m_t / (2 * half);
        b    = (f == 0) ? 63 : (f - 1) % 64;
        e_ws = (f > 0) && (b >= 31) && (b <= 62);
        if (f == 0)      e_d0 = 1'b0;
        else if (b == 0) e_d0 = m_prev[0];
        else             e_d0 = m_cur[64 - b];
        check_val("bck",          64'(i2s_bck),      64'((m_t / half) % 2));
        check_val("ws",           64'(i2s_ws),       64'(e_ws));
        check_val("d0",           64'(i2s_d0),       64'(e_d0));
        check_val("frame_strobe", 64'(frame_strobe), 64'(m_load));
        check_val("s_ready",      64'(s_ready),      64'(en && !reset && !m_full));
        check_val("underrun",     64'(underrun),     64'(m_under));
    endtask

    task automatic run_cycles(input int n, input bit refill);
        for (int i = 0; i < n; i++) begin
            tick();
            if (refill && m_acc) begin
                s_left  = 24'($urandom);
                s_right = 24'($urandom);
            end
        end
    endtask

    task automatic set_div(input int d);
        en      = 1'b0;
        bck_div = 8'(d);
        m_div   = d;
        tick();
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mute = 1'b0; s_valid = 1'b0; underrun_clr = 1'b0;
        bck_div = 8'd1; m_div = 1; s_left = 24'd0; s_right = 24'd0;
        m_t = 0; m_full = 0; m_armed = 0; m_under = 0; m_cur = '0; m_prev = '0;
        m_l = '0; m_r = '0; m_load = 0; m_acc = 0;
        run_cycles(3, 1'b0);
        en = 1'b1;
        run_cycles(2, 1'b0);
        reset = 1'b0; en = 1'b0;
        run_cycles(2, 1'b0);

        // bck_div = 1: one empty frame (not yet armed), then the directed pair, then underrun.
        en = 1'b1;
        run_cycles(256, 1'b0);
        s_left = 24'hABCDEF; s_right = 24'h123456; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        run_cycles(3 * 256, 1'b0);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        run_cycles(100, 1'b0);

        // Reset in the middle of a frame.
        reset = 1'b1;
        run_cycles(2, 1'b0);
        reset = 1'b0;

        // Back-pressure at clk/2: pairs always offered.
        set_div(0);
        s_left = 24'($urandom); s_right = 24'($urandom); s_valid = 1'b1;
        en = 1'b1;
        run_cycles(4 * 128 + 20, 1'b1);
        en = 1'b0;
        run_cycles(2, 1'b0);

        // Mute with continuous supply.
        set_div(2);
        mute = 1'b1; en = 1'b1;
        run_cycles(3 * 384 + 10, 1'b1);
        mute = 1'b0;

        // Random traffic, mute and clears over several divider settings.
        for (int r = 0; r < 3; r++) begin
            set_div(int'($urandom_range(0, 3)));
            en = 1'b1;
            for (int i = 0; i < 4 * 128 * (m_div + 1); i++) begin
                s_valid      = ($urandom_range(0, 99) < 2);
                s_left       = 24'($urandom);
                s_right      = 24'($urandom);
                underrun_clr = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 199) == 0) mute = ~mute;
                tick();
            end
            s_valid = 1'b0; underrun_clr = 1'b0; mute = 1'b0;
        end
        en = 1'b0;
        run_cycles(3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serializer stage that produces the amplifier's I2S stream (bck, ws, d0).
- Consumes stereo PCM sample pairs delivered by the upstream S/PDIF decode path over a valid/ready handshake.
- Generates bck from the system clock with a programmable divider and emits standard Philips I2S: MSB one bck after the ws edge, data left-justified in 32-bit slots.
- Sits between the S/PDIF sample path and the amp_i2s_* pins, inside the audio interface.

Parameters:
- SAMPLE_W, 24, PCM sample width per channel (must be <= SLOT_W-1).
- SLOT_W, 32, bck cycles per channel slot.
- DIV_W, 8, width of the bck divider control.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  block enable; low holds the serializer idle
- bck_div  in  DIV_W  bck half-period in clk cycles, minus 1
- mute  in  1  replace transmitted data with zeros
- s_valid  in  1  sample pair valid
- s_left  in  SAMPLE_W  left PCM sample, two's complement
- s_right  in  SAMPLE_W  right PCM sample, two's complement
- s_ready  out  1  holding register can accept a pair
- i2s_bck  out  1  bit clock
- i2s_ws  out  1  word select: 0 = left, 1 = right
- i2s_d0  out  1  serial data; changes on bck falling edge
- frame_strobe  out  1  one-clk pulse at each frame load
- underrun  out  1  sticky: a frame was loaded with no sample available
- underrun_clr  in  1  clears underrun

Behaviour:
- Reset (synchronous, active-high): all outputs 0, holding register empty, bit index b = 2*SLOT_W-1, divider count = 0, underrun armed flag cleared.
- en = 0: same idle state as reset, except underrun keeps its value. Holding register is flushed and s_ready = 0.
- Divider:
  - Counter runs 0..bck_div; at terminal count it wraps and toggles bck.
  - bck_div is sampled at each terminal count; a new value takes effect from the next half-period.
  - bck period = 2*(bck_div+1) clk. bck_div = 0 gives clk/2.
  - After en rises, bck rises after bck_div+1 clk and falls after another bck_div+1.
- Bit index b (0..2*SLOT_W-1) advances at every bck falling edge and wraps to 0.
  - The first falling edge after enable enters b = 0.
  - i2s_ws = 1 for b in SLOT_W-1 .. 2*SLOT_W-2; otherwise 0.
- Frame load, on the falling edge that enters b = 0:
  - If the holding register is full: frame <= {pad(left), pad(right)} and the holding register is emptied. pad() places the sample MSB-first in the slot, zero-filled below.
  - If it is empty: frame <= 0. underrun is set if armed.
  - mute = 1: frame <= 0 but the holding register is still consumed.
  - frame_strobe pulses high for one clk on this same clk.
- Data:
  - At the edge entering b = 0, d0 outputs the final bit of the previous frame (right LSB of the slot).
  - At the edge entering b = k (k >= 1), d0 outputs frame bit k-1, counted MSB-first, left slot then right slot.
  - The sink samples d0 on the bck rising edge.
- Handshake:
  - s_ready = en & ~hold_full.
  - A transfer occurs when s_valid & s_ready on a rising clk edge. hold_full is set on the next clk.
  - If a frame load and a new acceptance fall on the same clk, the load takes the old content and hold_full stays set with the new pair.
- Underrun arming and clear:
  - Underrun is armed by the first accepted pair after enable.
  - underrun_clr has priority over a simultaneous set.
- Latency: a pair accepted before a frame load has its left MSB on d0 from the falling edge entering b = 1.

Decomposition:
- toi2s_pkg gains:
  - I2S_SLOT_W and I2S_SAMPLE_W constants.
  - typedef struct packed { logic [23:0] left; logic [23:0] right; } pcm_pair_t.
  - Bit-index range constants for ws.
- One natural sub-module: i2s_clkgen. It holds the divider and produces i2s_bck plus single-clk bck_rise/bck_fall strobes.

Test Plan:
1. Idle and reset: reset = 1 or en = 0 -> bck/ws/d0/s_ready/frame_strobe = 0. Reset asserted mid-frame -> all outputs 0 on the next clk.
2. Timing, bck_div = 1, en = 1:
   - bck period = 4 clk; first rise 2 clk after en.
   - frame_strobe every 256 clk.
   - ws high for bck rising edges sampling b = 31..62.
3. Data: pair L = 0xABCDEF, R = 0x123456, sampled at bck rises:
   - b = 1..24 -> 0xABCDEF MSB-first; b = 25..32 -> 0.
   - b = 33..56 -> 0x123456; b = 57..63 and the next frame's b = 0 -> 0.
4. Underrun: one pair, then s_valid = 0 -> next frame all zeros, underrun = 1. Pulse underrun_clr -> underrun = 0. No underrun before the first sample.
5. Back-pressure: s_valid held with pairs A, B:
   - A accepted; s_ready = 0 until A's frame load; B accepted in the same clk window.
   - Frames transmit A then B in order.
6. Mute: mute = 1 with continuous valid pairs -> d0 constantly 0, pairs still consumed once per frame, underrun stays 0.
